instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the 32-bit pipelined MIPS core. Holds the PC, fetches from instruction memory over a valid/ready handshake, and delivers one instruction per cycle to the IF/ID register. It applies branch, jump and jump-register redirects resolved downstream, and honours stalls from the hazard unit. It is the block directly upstream of the datapath's `Instructions` input, and it consumes the datapath's `seOut` and `reg_Da` outputs.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `stall`  in  1: hazard unit; do not advance or start new fetches.
- `branch_taken`  in  1: EX-resolved taken branch.
- `branch_offset`  in  32: sign-extended word offset (datapath `seOut`).
- `redirect_pc4`  in  32: PC+4 of the redirecting instruction.
- `jump`  in  1: j/jal redirect.
- `jump_index`  in  26: instruction bits [25:0] of the jump.
- `jump_reg`  in  1: jr redirect.
- `reg_Da`  in  32: jr target (datapath `reg_Da`).
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch byte address.
- `imem_ready`  in  1: memory returns `imem_rdata` this cycle (may be combinational).
- `imem_rdata`  in  32: fetched word.
- `Instructions`  out  32: instruction to IF/ID.
- `instr_valid`  out  1: `Instructions` holds a real fetched instruction.
- `pc_plus4`  out  32: PC+4 of the instruction on `Instructions`.

## Operation
- Redirect target, in priority order:
  - `branch_taken`: `redirect_pc4 + (branch_offset << 2)`.
  - `jump_reg`: `reg_Da`.
  - `jump`: `{redirect_pc4[31:28], jump_index, 2'b00}`.
- All address arithmetic is modulo 2^32. Carries are dropped.
- A redirect is any of the three signals being high.
- FSM states: IDLE, REQ, DROP, HOLD.
  - IDLE: entered on reset. `imem_req=0`. Goes to REQ on the next cycle.
  - REQ: `imem_req=1`, `imem_addr=pc`. Address stays stable until `imem_ready`.
    - Redirect, with or without ready: `pc<=target`, output bubble. If ready was not seen, go to DROP; otherwise stay in REQ.
    - Ready, no redirect, no stall: `Instructions<=imem_rdata`, `instr_valid<=1`, `pc_plus4<=pc+4`, `pc<=pc+4`.
    - Ready with stall: capture the word in the skid register, `pc<=pc+4`, go to HOLD.
    - No ready, no redirect: wait.
  - DROP: `imem_req=1` with the stale address. On `imem_ready` the data is discarded and the FSM goes to REQ at the new pc. A further redirect while in DROP overwrites the target.
  - HOLD: `imem_req=0`.
    - On stall deassertion, the skid word goes to `Instructions` with `instr_valid=1`, then the FSM goes to REQ.
    - A redirect in HOLD discards the skid word, loads the target, and goes to REQ.
- Stall in REQ before ready: the request completes (handshake rule) and the FSM then follows the HOLD path.
- While `stall` is high, `Instructions`, `instr_valid` and `pc_plus4` hold their values.
- A bubble is `Instructions=32'h0` (sll $0 nop) with `instr_valid=0`.
- A redirect always wins over stall: the output is bubbled even when stalled.

## Timing
- Reset values: `pc=RESET_PC`, `imem_req=0`, `imem_addr=RESET_PC`, `Instructions=0`, `instr_valid=0`, `pc_plus4=0`, state IDLE, skid register 0.
- `rst` low mid-operation: all state returns to reset values on that edge. Any outstanding memory response is ignored.
- First request: the second edge after `rst` rises. First `instr_valid` follows one edge after the first `imem_ready`.
- Zero-wait memory: throughput 1 instruction/cycle. Fetch latency is 1 cycle from request to `Instructions`.
- Redirect: the target is requested on the cycle after the redirect edge, with exactly one bubble when the memory has zero wait states.

## Structure
- Package `mips_if_pkg` holds:
  - the state enum `if_state_t` (IDLE, REQ, DROP, HOLD);
  - the constants `NOP_INSTR=32'h0` and `DEFAULT_RESET_PC`.
- Sub-module `if_next_pc` is combinational. It performs redirect priority and target arithmetic and outputs `redirect` and `target`.
- The top level holds the FSM, PC, skid register and output registers.

## Test plan
- Reset then zero-wait memory returning `addr` as data → `Instructions` = 0, 4, 8, 12 on consecutive cycles, with `pc_plus4` = 4, 8, 12, 16.
- Two wait states per fetch → `imem_addr` stays stable for 3 cycles, and `instr_valid` pulses once every 3 cycles.
- `stall` held for 3 cycles while a response arrives → outputs frozen, word skidded, and released with no loss or duplication.
- `branch_taken` with `redirect_pc4=0x100`, `branch_offset=-2` → next `imem_addr=0xF8`, and exactly one bubble.
- `jump_reg` with `reg_Da=0x400` asserted during a wait state → stale word discarded, then `0x400` fetched.
- `branch_taken` and `jump` asserted together, and `rst` low during DROP → branch target chosen; after reset, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/mips_if_pkg.sv
// -----------------------------------------------------------------------------
// mips_if_pkg
// Shared types and constants for the MIPS instruction-fetch stage.
//   if_state_t       : fetch FSM state encoding (IDLE, REQ, DROP, HOLD)
//   NOP_INSTR        : bubble word (sll $0,$0,0)
//   DEFAULT_RESET_PC : default first fetch address after reset
// -----------------------------------------------------------------------------
package mips_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2,
      HOLD = 2'd3
   } if_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// -----------------------------------------------------------------------------
// if_next_pc
// Combinational redirect resolution for the fetch stage.
// Ports:
//   branch_taken, branch_offset, redirect_pc4 : taken branch and its operands
//   jump_reg, reg_Da                          : jr and its register target
//   jump, jump_index                          : j/jal and its 26-bit index
//   redirect                                  : any redirect requested
//   target                                    : redirect byte address
// Priority is branch, then jr, then j/jal.
// -----------------------------------------------------------------------------
module if_next_pc
   import mips_if_pkg::*;
(
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic [31:0] redirect_pc4,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] reg_Da,
   output logic        redirect,
   output logic [31:0] target
);

   always_comb begin
      redirect = branch_taken | jump_reg | jump;
      target   = redirect_pc4;
      if (branch_taken) begin
         // Word offset scaled to bytes; the top two offset bits fall off.
         target = redirect_pc4 + {branch_offset[29:0], 2'b00};
      end else if (jump_reg) begin
         target = reg_Da;
      end else if (jump) begin
         target = {redirect_pc4[31:28], jump_index, 2'b00};
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage: holds the PC, fetches from instruction memory over
// a req/ready handshake and feeds one instruction per cycle to IF/ID.
// Ports:
//   clk, rst (sync, active-low)
//   stall                              : hazard-unit freeze
//   branch_taken/branch_offset/redirect_pc4, jump/jump_index, jump_reg/reg_Da
//                                      : downstream redirects
//   imem_req, imem_addr                : fetch request to memory
//   imem_ready, imem_rdata             : memory response
//   Instructions, instr_valid, pc_plus4: IF/ID outputs
// -----------------------------------------------------------------------------
module instr_fetch
   import mips_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic [31:0] redirect_pc4,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] reg_Da,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instructions,
   output logic        instr_valid,
   output logic [31:0] pc_plus4
);

   if_state_t   r_state;
   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_addr;
   logic [31:0] r_skid;
   logic [31:0] r_instr;
   logic        r_valid;
   logic [31:0] r_pc_plus4;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_next;

   assign w_pc_next = r_pc + 32'd4;

   if_next_pc u_next_pc (
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .redirect_pc4  (redirect_pc4),
      .jump          (jump),
      .jump_index    (jump_index),
      .jump_reg      (jump_reg),
      .reg_Da        (reg_Da),
      .redirect      (w_redirect),
      .target        (w_target)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_skid     <= NOP_INSTR;
         r_instr    <= NOP_INSTR;
         r_valid    <= 1'b0;
         r_pc_plus4 <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= REQ;
               r_req   <= 1'b1;
               r_addr  <= r_pc;
            end

            REQ: begin
               if (w_redirect) begin
                  // Redirect beats stall: bubble even when frozen.
                  r_pc    <= w_target;
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
                  if (imem_ready) begin
                     r_addr <= w_target;
                  end else begin
                     // Request in flight must finish at the old address.
                     r_state <= DROP;
                  end
               end else if (imem_ready) begin
                  r_pc   <= w_pc_next;
                  r_addr <= w_pc_next;
                  if (stall) begin
                     r_skid  <= imem_rdata;
                     r_req   <= 1'b0;
                     r_state <= HOLD;
                  end else begin
                     r_instr    <= imem_rdata;
                     r_valid    <= 1'b1;
                     r_pc_plus4 <= w_pc_next;
                  end
               end else if (!stall) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end
            end

            DROP: begin
               if (w_redirect) begin
                  r_pc <= w_target;
               end
               if (imem_ready) begin
                  // Stale word is thrown away; fetch resumes at latest target.
                  r_state <= REQ;
                  r_addr  <= w_redirect ? w_target : r_pc;
               end
               if (w_redirect || !stall) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end
            end

            HOLD: begin
               if (w_redirect) begin
                  r_pc    <= w_target;
                  r_addr  <= w_target;
                  r_req   <= 1'b1;
                  r_skid  <= NOP_INSTR;
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
                  r_state <= REQ;
               end else if (!stall) begin
                  // pc already advanced past the skid word, so it is its PC+4.
                  r_instr    <= r_skid;
                  r_valid    <= 1'b1;
                  r_pc_plus4 <= r_pc;
                  r_addr     <= r_pc;
                  r_req      <= 1'b1;
                  r_state    <= REQ;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign imem_req     = r_req;
   assign imem_addr    = r_addr;
   assign Instructions = r_instr;
   assign instr_valid  = r_valid;
   assign pc_plus4     = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. The memory model returns the fetch address
// as data; imem_ready is driven step by step to create wait states.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic [31:0] redirect_pc4;
   logic        jump;
   logic [25:0] jump_index;
   logic        jump_reg;
   logic [31:0] reg_Da;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] Instructions;
   logic        instr_valid;
   logic [31:0] pc_plus4;

   int errors = 0;
   int checks = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .redirect_pc4  (redirect_pc4),
      .jump          (jump),
      .jump_index    (jump_index),
      .jump_reg      (jump_reg),
      .reg_Da        (reg_Da),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .Instructions  (Instructions),
      .instr_valid   (instr_valid),
      .pc_plus4      (pc_plus4)
   );

   assign imem_rdata = imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic out(input string tag, input logic [31:0] ins, input logic v, input logic [31:0] p4);
      chk({tag, ".instr"}, Instructions, ins);
      chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
      chk({tag, ".pc4"}, pc_plus4, p4);
      $display("step %-10s addr=%h req=%b instr=%h valid=%b pc4=%h",
               tag, imem_addr, imem_req, Instructions, instr_valid, pc_plus4);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
      redirect_pc4 = 32'h0; jump = 1'b0; jump_index = 26'h0; jump_reg = 1'b0;
      reg_Da = 32'h0; imem_ready = 1'b0;
      tick(); tick();
      chk("rst.req", {31'b0, imem_req}, 32'h0);
      chk("rst.addr", imem_addr, 32'h0);
      out("rst", 32'h0, 1'b0, 32'h0);

      // Zero-wait streaming from RESET_PC
      rst = 1'b1; imem_ready = 1'b1;
      tick();
      chk("first.req", {31'b0, imem_req}, 32'h1);
      chk("first.addr", imem_addr, 32'h0);
      chk("first.valid", {31'b0, instr_valid}, 32'h0);
      tick(); out("seq0", 32'h0, 1'b1, 32'h4);
      tick(); out("seq1", 32'h4, 1'b1, 32'h8);
      tick(); out("seq2", 32'h8, 1'b1, 32'hC);
      tick(); out("seq3", 32'hC, 1'b1, 32'h10);
      chk("seq3.addr", imem_addr, 32'h10);

      // Two wait states per fetch
      imem_ready = 1'b0;
      tick(); chk("w0a.addr", imem_addr, 32'h10); out("w0a", 32'h0, 1'b0, 32'h10);
      tick(); chk("w0b.addr", imem_addr, 32'h10); out("w0b", 32'h0, 1'b0, 32'h10);
      imem_ready = 1'b1;
      tick(); out("w0c", 32'h10, 1'b1, 32'h14);
      imem_ready = 1'b0;
      tick(); chk("w1a.addr", imem_addr, 32'h14); chk("w1a.valid", {31'b0, instr_valid}, 32'h0);
      tick(); chk("w1b.addr", imem_addr, 32'h14); chk("w1b.valid", {31'b0, instr_valid}, 32'h0);
      imem_ready = 1'b1;
      tick(); out("w1c", 32'h14, 1'b1, 32'h18);
      chk("w1c.addr", imem_addr, 32'h18);

      // Stall for 3 cycles while the response for 0x18 arrives
      stall = 1'b1;
      tick(); chk("st0.req", {31'b0, imem_req}, 32'h0); out("st0", 32'h14, 1'b1, 32'h18);
      imem_ready = 1'b0;
      tick(); out("st1", 32'h14, 1'b1, 32'h18);
      tick(); out("st2", 32'h14, 1'b1, 32'h18);
      stall = 1'b0; imem_ready = 1'b1;
      tick(); out("rel", 32'h18, 1'b1, 32'h1C);
      chk("rel.addr", imem_addr, 32'h1C);
      tick(); out("rel+1", 32'h1C, 1'b1, 32'h20);

      // Taken branch: 0x100 + (-2 << 2) = 0xF8, one bubble
      branch_taken = 1'b1; redirect_pc4 = 32'h100; branch_offset = 32'hFFFF_FFFE;
      tick(); chk("br.addr", imem_addr, 32'hF8);
      chk("br.instr", Instructions, 32'h0); chk("br.valid", {31'b0, instr_valid}, 32'h0);
      branch_taken = 1'b0;
      tick(); out("br+1", 32'hF8, 1'b1, 32'hFC);

      // jr during a wait state: stale word dropped, then 0x400 fetched
      imem_ready = 1'b0;
      tick(); chk("jr.wait.addr", imem_addr, 32'hFC);
      jump_reg = 1'b1; reg_Da = 32'h400;
      tick(); chk("jr.drop.addr", imem_addr, 32'hFC);
      chk("jr.drop.req", {31'b0, imem_req}, 32'h1);
      chk("jr.drop.valid", {31'b0, instr_valid}, 32'h0);
      jump_reg = 1'b0; imem_ready = 1'b1;
      tick(); chk("jr.disc.addr", imem_addr, 32'h400); out("jr.disc", 32'h0, 1'b0, 32'hFC);
      tick(); out("jr.tgt", 32'h400, 1'b1, 32'h404);

      // Branch and jump together: branch target 0x2000 + 12 wins over 0x100
      imem_ready = 1'b0; branch_taken = 1'b1; jump = 1'b1;
      redirect_pc4 = 32'h2000; branch_offset = 32'h3; jump_index = 26'h40;
      tick(); chk("bj.drop.addr", imem_addr, 32'h404);
      branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
      tick(); chk("bj.addr", imem_addr, 32'h200C);
      tick(); out("bj.tgt", 32'h200C, 1'b1, 32'h2010);

      // Plain jump keeps the upper PC nibble
      jump = 1'b1; redirect_pc4 = 32'h3000_0000; jump_index = 26'h40;
      tick(); chk("j.addr", imem_addr, 32'h3000_0100);
      jump = 1'b0;
      tick(); out("j.tgt", 32'h3000_0100, 1'b1, 32'h3000_0104);

      // Reset while in DROP: pending response and target forgotten
      imem_ready = 1'b0; jump_reg = 1'b1; reg_Da = 32'h800;
      tick(); chk("rd.drop.addr", imem_addr, 32'h3000_0104);
      jump_reg = 1'b0; rst = 1'b0; imem_ready = 1'b1;
      tick(); chk("rd.req", {31'b0, imem_req}, 32'h0); chk("rd.addr", imem_addr, 32'h0);
      out("rd", 32'h0, 1'b0, 32'h0);
      rst = 1'b1;
      tick(); chk("rd.idle.req", {31'b0, imem_req}, 32'h1); chk("rd.idle.addr", imem_addr, 32'h0);
      tick(); out("rd.first", 32'h0, 1'b1, 32'h4);
      tick(); out("rd.second", 32'h4, 1'b1, 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
